// File: rtl/hallway_column_drawer.sv
// Column drawer: streams one vertical column of pixels (rows 0..HEIGHT-1) with
// colours derived from two tracer rows, honouring a ready/valid pixel handshake.
module hallway_column_drawer #(
   parameter int                X_W         = 8,
   parameter int                Y_W         = 7,
   parameter int                HEIGHT      = 120,
   parameter int                COL_W       = 3,
   parameter logic [COL_W-1:0]  WALL_COLOUR = '1,
   parameter logic [COL_W-1:0]  BG_COLOUR   = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [X_W-1:0]    columnSpecifier,
   input  logic [Y_W-1:0]    upperTracerPos,
   input  logic [Y_W-1:0]    lowerTracerPos,
   input  logic              pixelReady,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic [COL_W-1:0]  colour,
   output logic              writeEn,
   output logic              done
);

   typedef enum logic {IDLE, DRAW} state_t;

   localparam int unsigned     LAST_I   = HEIGHT - 1;
   localparam logic [Y_W-1:0]  LAST_ROW = LAST_I[Y_W-1:0];

   state_t            state;
   logic [1:0]        mode_q;
   logic [X_W-1:0]    col_q;
   logic [Y_W-1:0]    upper_q;
   logic [Y_W-1:0]    lower_q;
   logic [Y_W-1:0]    row;
   logic [Y_W-1:0]    next_row;
   logic [COL_W-1:0]  next_colour;
   logic              wall;

   // The first DRAW cycle presents row 0; afterwards each accepted pixel moves on.
   always_comb begin
      next_row = writeEn ? row + Y_W'(1) : row;
      wall     = 1'b0;
      case (mode_q)
         2'b00:   wall = (next_row == upper_q) || (next_row == lower_q);
         2'b01:   wall = (next_row <= upper_q) || (next_row >= lower_q);
         default: wall = 1'b0;
      endcase
      next_colour = wall ? WALL_COLOUR : BG_COLOUR;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         mode_q  <= '0;
         col_q   <= '0;
         upper_q <= '0;
         lower_q <= '0;
         row     <= '0;
         x       <= '0;
         y       <= '0;
         colour  <= '0;
         writeEn <= 1'b0;
         done    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q  <= mode;
                  col_q   <= columnSpecifier;
                  upper_q <= upperTracerPos;
                  lower_q <= lowerTracerPos;
                  row     <= '0;
                  done    <= 1'b0;
                  state   <= DRAW;
               end
            end
            DRAW: begin
               if (!writeEn || pixelReady) begin
                  if (writeEn && row == LAST_ROW) begin
                     state   <= IDLE;
                     row     <= '0;
                     x       <= '0;
                     y       <= '0;
                     colour  <= '0;
                     writeEn <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     row     <= next_row;
                     x       <= col_q;
                     y       <= next_row;
                     colour  <= next_colour;
                     writeEn <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hallway_column_drawer.sv
// Self-checking bench: cycle-level reference model plus directed and random columns.
module tb_hallway_column_drawer;
   localparam int X_W = 8, Y_W = 7, HEIGHT = 120, COL_W = 3;
   localparam logic [COL_W-1:0] WALL = '1;
   localparam logic [COL_W-1:0] BG   = '0;

   logic              clock = 1'b0;
   logic              reset, start, pixelReady;
   logic [1:0]        mode;
   logic [X_W-1:0]    columnSpecifier;
   logic [Y_W-1:0]    upperTracerPos, lowerTracerPos;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [COL_W-1:0]  colour;
   logic              writeEn, done;

   int checks = 0, errors = 0;

   hallway_column_drawer #(.X_W(X_W), .Y_W(Y_W), .HEIGHT(HEIGHT), .COL_W(COL_W),
                           .WALL_COLOUR(WALL), .BG_COLOUR(BG)) dut (
      .clock(clock), .reset(reset), .start(start), .mode(mode),
      .columnSpecifier(columnSpecifier), .upperTracerPos(upperTracerPos),
      .lowerTracerPos(lowerTracerPos), .pixelReady(pixelReady),
      .x(x), .y(y), .colour(colour), .writeEn(writeEn), .done(done));

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a column is a list of rows 0..HEIGHT-1; one edge to show
   // the first row, then each ready edge retires the shown row.
   bit   m_busy = 0, m_shown = 0;
   int   m_row = 0, m_mode = 0, m_col = 0, m_up = 0, m_lo = 0;

   function automatic logic [COL_W-1:0] ref_colour(int md, int up, int lo, int r);
      case (md)
         0:       return (r == up || r == lo) ? WALL : BG;
         1:       return (r <= up || r >= lo) ? WALL : BG;
         default: return BG;
      endcase
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_busy = 0; m_shown = 0; m_row = 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_shown = 0; m_row = 0;
            m_mode = mode; m_col = columnSpecifier;
            m_up = upperTracerPos; m_lo = lowerTracerPos;
         end
      end else if (!m_shown) begin
         m_shown = 1;
      end else if (pixelReady) begin
         if (m_row == HEIGHT - 1) begin
            m_busy = 0; m_shown = 0; m_row = 0;
         end else m_row++;
      end
   end

   // Per-column statistics of the pixels the DUT actually handed over.
   int n_wr, n_wall;
   int seen [HEIGHT];
   bit wallrow [HEIGHT];

   task automatic clear_stats();
      n_wr = 0; n_wall = 0;
      for (int r = 0; r < HEIGHT; r++) begin seen[r] = 0; wallrow[r] = 0; end
   endtask

   always @(negedge clock) begin
      chk("writeEn", writeEn, m_shown);
      chk("done", done, !m_busy);
      chk("x", x, m_shown ? m_col : 0);
      chk("y", y, m_shown ? m_row : 0);
      chk("colour", colour, m_shown ? ref_colour(m_mode, m_up, m_lo, m_row) : 0);
      if (writeEn && pixelReady && !reset && y < HEIGHT) begin
         n_wr++;
         seen[y]++;
         if (colour == WALL) begin n_wall++; wallrow[y] = 1; end
      end
   end

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic launch(input int md, input int col, input int up, input int lo);
      mode = md[1:0]; columnSpecifier = col[X_W-1:0];
      upperTracerPos = up[Y_W-1:0]; lowerTracerPos = lo[Y_W-1:0];
      clear_stats();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // rmode: 0 ready high, 1 ready toggling, 2 random ready/start, 3 stray start at cycle 20
   task automatic wait_done(input int rmode, output int cyc);
      cyc = 0;
      do begin
         case (rmode)
            0: pixelReady = 1'b1;
            1: pixelReady = ~pixelReady;
            2: begin
               pixelReady      = ($urandom % 4) != 0;
               start           = ($urandom % 8) == 0;
               mode            = 2'($urandom);
               columnSpecifier = X_W'($urandom);
               upperTracerPos  = Y_W'($urandom);
               lowerTracerPos  = Y_W'($urandom);
            end
            default: begin
               pixelReady = 1'b1;
               start = (cyc == 20);
               if (cyc == 20) begin
                  mode = 2'b01; columnSpecifier = 8'd200;
                  upperTracerPos = 7'd5; lowerTracerPos = 7'd6;
               end
            end
         endcase
         tick();
         cyc++;
      end while (!done && cyc < 1000);
      start = 1'b0;
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic check_rows(input string name);
      int bad = 0;
      for (int r = 0; r < HEIGHT; r++) if (seen[r] != 1) bad++;
      chk({name, "_rows_once"}, bad, 0);
      chk({name, "_writes"}, n_wr, HEIGHT);
   endtask

   int cyc;

   initial begin
      reset = 1'b1; start = 1'b0; pixelReady = 1'b0; mode = '0;
      columnSpecifier = '0; upperTracerPos = '0; lowerTracerPos = '0;
      clear_stats();
      tick(); tick();
      chk("rst_done", done, 1); chk("rst_we", writeEn, 0);
      chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_colour", colour, 0);
      reset = 1'b0;
      repeat (3) tick();
      chk("idle_done", done, 1); chk("idle_we", writeEn, 0);

      // EDGE column, ready always high
      pixelReady = 1'b1;
      launch(0, 37, 10, 100);
      chk("edge_first_we", writeEn, 0);
      chk("edge_first_done", done, 0);
      wait_done(0, cyc);
      chk("edge_cycles", cyc, HEIGHT + 1);
      check_rows("edge");
      chk("edge_wall_count", n_wall, 2);
      chk("edge_wall10", wallrow[10], 1);
      chk("edge_wall100", wallrow[100], 1);

      // FILL, normal and crossed tracers
      launch(1, 12, 10, 100);
      wait_done(0, cyc);
      check_rows("fill");
      chk("fill_wall_count", n_wall, 31);
      chk("fill_wall10", wallrow[10], 1);
      chk("fill_bg11", wallrow[11], 0);
      chk("fill_bg99", wallrow[99], 0);
      chk("fill_wall100", wallrow[100], 1);
      launch(1, 12, 60, 50);
      wait_done(0, cyc);
      chk("fill_cross_wall", n_wall, HEIGHT);

      // Ready toggling every cycle
      launch(0, 5, 0, 119);
      wait_done(1, cyc);
      check_rows("toggle");
      chk("toggle_cycles", (cyc >= 240 && cyc <= 241), 1);

      // Stray start mid-column is ignored
      launch(0, 37, 10, 100);
      wait_done(3, cyc);
      check_rows("stray");
      chk("stray_wall_count", n_wall, 2);
      chk("stray_wall100", wallrow[100], 1);
      tick();
      chk("stray_idle", done, 1);

      // Reset at row 57
      pixelReady = 1'b1;
      launch(1, 99, 20, 80);
      cyc = 0;
      do begin tick(); cyc++; end while (y != 7'd57 && cyc < 200);
      chk("reach_row57", y, 57);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_we", writeEn, 0); chk("mid_rst_done", done, 1);
      chk("mid_rst_x", x, 0); chk("mid_rst_y", y, 0); chk("mid_rst_colour", colour, 0);
      launch(1, 99, 20, 80);
      tick();
      chk("redraw_y0", y, 0); chk("redraw_we", writeEn, 1);
      wait_done(0, cyc);

      // Reserved mode behaves as CLEAR
      launch(3, 64, 0, 119);
      wait_done(0, cyc);
      check_rows("clear");
      chk("clear_wall_count", n_wall, 0);

      // Random columns with random back-pressure and stray starts
      for (int i = 0; i < 25; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         launch($urandom_range(0, 3), $urandom_range(0, 255),
                $urandom_range(0, 127), $urandom_range(0, 127));
         wait_done(2, cyc);
         check_rows("rand");
      end

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
